flash_read_arbiter: RTL

- Shares the single memory-mapped read port of flash_controller between two requesters: CPU fetch (port "cpu") and DMA/sprite fetch (port "dma").
- Issues one outstanding read at a time, captures the address at grant, routes the returned word back to the granted requester, and guards against a hung controller with a timeout.
- Sits between the bus fabric and flash_controller's mem_* interface.

---
 rtl/flash_read_arbiter_if.sv | 45 ++++
 rtl/flash_read_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/flash_read_arbiter_if.sv
// Bus bundle for flash_read_arbiter: both requester ports (cpu, dma), the
// hold input, the flash_controller mem_* read port and the status outputs.
//   slave  : arbiter side (takes requests and flash returns, drives results)
//   master : environment side (requesters plus flash_controller)
// Signal summary:
//   cpu_addr/cpu_RD_ready -> request in;  cpu_RD_valid/cpu_data_out <- result
//   dma_addr/dma_RD_ready -> request in;  dma_RD_valid/dma_data_out <- result
//   hold                  -> blocks new grants
//   flash_mem_addr/flash_mem_RD_ready     <- read issued to flash_controller
//   flash_mem_RD_valid/flash_mem_data_in  -> read data returned
//   grant_dma/timeout_err                 <- owner of last grant, sticky error
interface flash_read_arbiter_if #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32
);
  logic [ADDR_BITS-1:0] cpu_addr;
  logic                 cpu_RD_ready;
  logic                 cpu_RD_valid;
  logic [DATA_BITS-1:0] cpu_data_out;
  logic [ADDR_BITS-1:0] dma_addr;
  logic                 dma_RD_ready;
  logic                 dma_RD_valid;
  logic [DATA_BITS-1:0] dma_data_out;
  logic                 hold;
  logic [ADDR_BITS-1:0] flash_mem_addr;
  logic                 flash_mem_RD_ready;
  logic                 flash_mem_RD_valid;
  logic [DATA_BITS-1:0] flash_mem_data_in;
  logic                 grant_dma;
  logic                 timeout_err;

  modport slave (
    input  cpu_addr, cpu_RD_ready, dma_addr, dma_RD_ready, hold,
           flash_mem_RD_valid, flash_mem_data_in,
    output cpu_RD_valid, cpu_data_out, dma_RD_valid, dma_data_out,
           flash_mem_addr, flash_mem_RD_ready, grant_dma, timeout_err
  );

  modport master (
    output cpu_addr, cpu_RD_ready, dma_addr, dma_RD_ready, hold,
           flash_mem_RD_valid, flash_mem_data_in,
    input  cpu_RD_valid, cpu_data_out, dma_RD_valid, dma_data_out,
           flash_mem_addr, flash_mem_RD_ready, grant_dma, timeout_err
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares flash_controller's single read port between the
// cpu fetch port and the dma/sprite fetch port. One read is outstanding at a
// time; the address is captured at grant, the returned word is routed to the
// granted port with a one-cycle valid pulse, and a hung controller is cut off
// after TIMEOUT_CYCLES with all-ones data and a sticky timeout_err.
// Ports:
//   CLK   : system clock
//   RSTb  : synchronous active-low reset
//   bus   : flash_read_arbiter_if.slave (requesters, hold, flash mem_* port,
//           grant_dma, timeout_err)
module flash_read_arbiter #(
  parameter int ADDR_BITS      = 24,
  parameter int DATA_BITS      = 32,
  parameter int CPU_PRIORITY   = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  flash_read_arbiter_if.slave   bus
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 12) ? $clog2(TIMEOUT_CYCLES) : 12;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               r_state,       w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,         w_cnt_nxt;
  logic                 r_last_dma,    w_last_dma_nxt;
  logic [ADDR_BITS-1:0] r_flash_addr,  w_flash_addr_nxt;
  logic                 r_flash_rdy,   w_flash_rdy_nxt;
  logic                 r_grant_dma,   w_grant_dma_nxt;
  logic                 r_timeout_err, w_timeout_err_nxt;
  logic                 r_cpu_vld,     w_cpu_vld_nxt;
  logic [DATA_BITS-1:0] r_cpu_data,    w_cpu_data_nxt;
  logic                 r_dma_vld,     w_dma_vld_nxt;
  logic [DATA_BITS-1:0] r_dma_data,    w_dma_data_nxt;

  logic                 w_win_dma;
  logic                 w_done;
  logic [DATA_BITS-1:0] w_ret_data;

  // dma wins when it is the only requester, or on contention when round-robin
  // is selected and the previous grant went to the cpu.
  assign w_win_dma = bus.dma_RD_ready &&
                     (!bus.cpu_RD_ready || ((CPU_PRIORITY == 0) && !r_last_dma));

  // A real return beats the timeout when both land on the same cycle.
  assign w_done     = bus.flash_mem_RD_valid || (r_cnt == CNT_LIMIT);
  assign w_ret_data = bus.flash_mem_RD_valid ? bus.flash_mem_data_in : '1;

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_last_dma_nxt    = r_last_dma;
    w_flash_addr_nxt  = r_flash_addr;
    w_flash_rdy_nxt   = r_flash_rdy;
    w_grant_dma_nxt   = r_grant_dma;
    w_timeout_err_nxt = r_timeout_err;
    w_cpu_vld_nxt     = 1'b0;
    w_cpu_data_nxt    = r_cpu_data;
    w_dma_vld_nxt     = 1'b0;
    w_dma_data_nxt    = r_dma_data;

    case (r_state)
      IDLE: begin
        if (!bus.hold && (bus.cpu_RD_ready || bus.dma_RD_ready)) begin
          w_state_nxt      = ISSUE;
          w_flash_addr_nxt = w_win_dma ? bus.dma_addr : bus.cpu_addr;
          w_flash_rdy_nxt  = 1'b1;
          w_grant_dma_nxt  = w_win_dma;
          w_last_dma_nxt   = w_win_dma;
          w_cnt_nxt        = '0;
        end
      end
      ISSUE: begin
        if (w_done) begin
          w_state_nxt     = IDLE;
          w_flash_rdy_nxt = 1'b0;
          if (!bus.flash_mem_RD_valid) w_timeout_err_nxt = 1'b1;
          if (r_grant_dma) begin
            w_dma_data_nxt = w_ret_data;
            w_dma_vld_nxt  = 1'b1;
          end else begin
            w_cpu_data_nxt = w_ret_data;
            w_cpu_vld_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers; the pointer resets to "dma last" so the cpu
  // takes the first contention.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_last_dma    <= 1'b1;
      r_flash_addr  <= '0;
      r_flash_rdy   <= 1'b0;
      r_grant_dma   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cpu_vld     <= 1'b0;
      r_cpu_data    <= '0;
      r_dma_vld     <= 1'b0;
      r_dma_data    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_last_dma    <= w_last_dma_nxt;
      r_flash_addr  <= w_flash_addr_nxt;
      r_flash_rdy   <= w_flash_rdy_nxt;
      r_grant_dma   <= w_grant_dma_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_cpu_vld     <= w_cpu_vld_nxt;
      r_cpu_data    <= w_cpu_data_nxt;
      r_dma_vld     <= w_dma_vld_nxt;
      r_dma_data    <= w_dma_data_nxt;
    end
  end

  assign bus.flash_mem_addr     = r_flash_addr;
  assign bus.flash_mem_RD_ready = r_flash_rdy;
  assign bus.grant_dma          = r_grant_dma;
  assign bus.timeout_err        = r_timeout_err;
  assign bus.cpu_RD_valid       = r_cpu_vld;
  assign bus.cpu_data_out       = r_cpu_data;
  assign bus.dma_RD_valid       = r_dma_vld;
  assign bus.dma_data_out       = r_dma_data;

endmodule
